// File: rtl/tx_rrc_shaper_if.sv
// Symbol-in / sample-out port bundle of the transmit pulse shaper.
// The master is the symbol source and sample sink; the slave is the shaper.
interface tx_rrc_shaper_if #(
   parameter int DATA_NBITS = 8
) ();
   logic                         tx_in;
   logic                         tx_valid;
   logic                         tx_ready;
   logic signed [DATA_NBITS-1:0] tx_out;
   logic                         tx_out_valid;
   logic                         tx_underrun;

   modport master (
      output tx_in, tx_valid,
      input  tx_ready, tx_out, tx_out_valid, tx_underrun
   );

   modport slave (
      input  tx_in, tx_valid,
      output tx_ready, tx_out, tx_out_valid, tx_underrun
   );
endinterface

// File: rtl/tx_rrc_shaper.sv
// One-rail QPSK pulse shaper: bit -> +/-1, zero-stuffed by UPSAMPLE, shaped by a
// multiplier-free transposed FIR and saturated to S(DATA_NBITS,COEF_FBITS).
module tx_rrc_shaper #(
   parameter int                          UPSAMPLE   = 4,
   parameter int                          NCOEF      = 24,
   parameter int                          COEF_NBITS = 8,
   parameter int                          COEF_FBITS = 7,
   parameter int                          DATA_NBITS = 8,
   parameter logic [NCOEF*COEF_NBITS-1:0] COEF       = '0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable,
   tx_rrc_shaper_if.slave tx
);
   localparam int ACC_NBITS = COEF_NBITS + $clog2(NCOEF);
   localparam int SUM_NBITS = ((ACC_NBITS > DATA_NBITS) ? ACC_NBITS : DATA_NBITS) + 1;
   localparam int PH_NBITS  = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
   localparam logic [PH_NBITS-1:0]         PH_LAST = PH_NBITS'(UPSAMPLE - 1);
   localparam logic signed [SUM_NBITS-1:0] OUT_MAX = SUM_NBITS'((2 ** (DATA_NBITS - 1)) - 1);
   localparam logic signed [SUM_NBITS-1:0] OUT_MIN = ~OUT_MAX;

   if (COEF_FBITS >= COEF_NBITS || DATA_NBITS < COEF_NBITS || NCOEF < 2) begin : g_param_check
      $error("tx_rrc_shaper: unsupported parameter set");
   end

   logic [PH_NBITS-1:0]          ph_reg;
   logic signed [COEF_NBITS-1:0] coef_init [NCOEF];
   logic signed [COEF_NBITS-1:0] coef_reg  [NCOEF];
   logic signed [ACC_NBITS-1:0]  prod      [NCOEF];
   logic signed [ACC_NBITS-1:0]  acc_reg   [1:NCOEF-1];
   logic signed [ACC_NBITS-1:0]  y_acc;
   logic signed [SUM_NBITS-1:0]  y_wide;
   logic signed [DATA_NBITS-1:0] y_sat;
   logic signed [DATA_NBITS-1:0] out_reg;
   logic                         out_valid_reg;
   logic                         underrun_reg;
   logic                         slot;
   logic                         x_pos;
   logic                         x_neg;

   // Tap 0 sits in the most significant slice of COEF.
   for (genvar gi = 0; gi < NCOEF; gi++) begin : g_tap
      assign coef_init[gi] = COEF[(NCOEF-1-gi)*COEF_NBITS +: COEF_NBITS];
      assign prod[gi] = x_pos ? ACC_NBITS'(coef_reg[gi]) :
                        x_neg ? -ACC_NBITS'(coef_reg[gi]) : '0;
   end

   assign slot        = (ph_reg == '0);
   assign tx.tx_ready = enable & slot & ~rst;
   assign x_pos       = tx.tx_ready & tx.tx_valid & tx.tx_in;
   assign x_neg       = tx.tx_ready & tx.tx_valid & ~tx.tx_in;

   assign y_acc  = prod[0] + acc_reg[1];
   assign y_wide = SUM_NBITS'(y_acc);

   always_comb begin
      y_sat = y_wide[DATA_NBITS-1:0];
      if (y_wide > OUT_MAX) begin
         y_sat = OUT_MAX[DATA_NBITS-1:0];
      end else if (y_wide < OUT_MIN) begin
         y_sat = OUT_MIN[DATA_NBITS-1:0];
      end
   end

   // The output register takes the sample computed from the impulse applied on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ph_reg        <= '0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         underrun_reg  <= 1'b0;
         for (int i = 0; i < NCOEF; i++) begin
            coef_reg[i] <= coef_init[i];
         end
         for (int i = 1; i < NCOEF; i++) begin
            acc_reg[i] <= '0;
         end
      end else begin
         out_valid_reg <= enable;
         underrun_reg  <= enable & slot & ~tx.tx_valid;
         if (enable) begin
            ph_reg  <= (ph_reg == PH_LAST) ? '0 : ph_reg + PH_NBITS'(1);
            out_reg <= y_sat;
            for (int i = 1; i < NCOEF - 1; i++) begin
               acc_reg[i] <= acc_reg[i+1] + prod[i];
            end
            acc_reg[NCOEF-1] <= prod[NCOEF-1];
         end
      end
   end

   assign tx.tx_out       = out_reg;
   assign tx.tx_out_valid = out_valid_reg;
   assign tx.tx_underrun  = underrun_reg;
endmodule

// File: tb/tb_tx_rrc_shaper.sv
// Bench for tx_rrc_shaper: a ramp-tap and a full-scale-tap instance share one stimulus
// and are checked against a direct convolution model of the zero-stuffed symbol stream.
module tb_tx_rrc_shaper;
   localparam int UPS = 4;
   localparam int NC  = 24;
   localparam int CNB = 8;
   localparam int DNB = 8;

   function automatic logic [NC*CNB-1:0] pack_coef(input int mode);
      logic [NC*CNB-1:0] p;
      p = '0;
      for (int i = 0; i < NC; i++) begin
         p[(NC-1-i)*CNB +: CNB] = (mode == 0) ? CNB'(i + 1) : CNB'(127);
      end
      return p;
   endfunction

   localparam logic [NC*CNB-1:0] COEF_RAMP = pack_coef(0);
   localparam logic [NC*CNB-1:0] COEF_FULL = pack_coef(1);

   logic clk = 1'b0;
   logic rst, enable, tx_in, tx_valid;
   int   chk = 0;
   int   err = 0;

   tx_rrc_shaper_if #(.DATA_NBITS(DNB)) if_r ();
   tx_rrc_shaper_if #(.DATA_NBITS(DNB)) if_s ();

   assign if_r.tx_in    = tx_in;
   assign if_r.tx_valid = tx_valid;
   assign if_s.tx_in    = tx_in;
   assign if_s.tx_valid = tx_valid;

   tx_rrc_shaper #(.UPSAMPLE(UPS), .NCOEF(NC), .COEF_NBITS(CNB), .COEF_FBITS(7),
                   .DATA_NBITS(DNB), .COEF(COEF_RAMP))
      dut_ramp (.clk(clk), .rst(rst), .enable(enable), .tx(if_r));

   tx_rrc_shaper #(.UPSAMPLE(UPS), .NCOEF(NC), .COEF_NBITS(CNB), .COEF_FBITS(7),
                   .DATA_NBITS(DNB), .COEF(COEF_FULL))
      dut_full (.clk(clk), .rst(rst), .enable(enable), .tx(if_s));

   always #5 clk = ~clk;

   // Reference model: impulse history (newest first), enable count within the symbol period.
   int coef_m [2][NC];
   int hist   [NC];
   int cnt;
   int exp_out [2];
   bit exp_ov, exp_ur;

   function automatic int sat_model(input int y);
      if (y > 2 ** (DNB - 1) - 1) return 2 ** (DNB - 1) - 1;
      if (y < -(2 ** (DNB - 1))) return -(2 ** (DNB - 1));
      return y;
   endfunction

   function automatic bit exp_ready();
      return (enable === 1'b1) && (rst === 1'b0) && (cnt == 0);
   endfunction

   task automatic tick();
      bit r, e, v, b;
      int x, y;
      r = rst; e = enable; v = tx_valid; b = tx_in;
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < NC; i++) hist[i] = 0;
         cnt = 0; exp_out[0] = 0; exp_out[1] = 0; exp_ov = 0; exp_ur = 0;
      end else begin
         exp_ov = e;
         exp_ur = 0;
         if (e) begin
            x = 0;
            if (cnt == 0) begin
               if (v) x = b ? 1 : -1;
               else exp_ur = 1;
            end
            for (int i = NC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = x;
            for (int d = 0; d < 2; d++) begin
               y = 0;
               for (int i = 0; i < NC; i++) y += coef_m[d][i] * hist[i];
               exp_out[d] = sat_model(y);
            end
            cnt = (cnt + 1) % UPS;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1; enable = 1; tx_valid = 1; tx_in = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk++;
         if (if_r.tx_ready !== 1'b0 || if_s.tx_ready !== 1'b0) begin
            err++; $display("FAIL reset_ready cyc %0d got %b/%b want 0", k, if_r.tx_ready, if_s.tx_ready);
         end
         tick();
         chk++;
         if ({if_r.tx_out, if_r.tx_out_valid, if_r.tx_underrun} !== 10'd0 ||
             {if_s.tx_out, if_s.tx_out_valid, if_s.tx_underrun} !== 10'd0) begin
            err++; $display("FAIL reset_outputs cyc %0d got %h/%h want 000", k,
                            {if_r.tx_out, if_r.tx_out_valid, if_r.tx_underrun},
                            {if_s.tx_out, if_s.tx_out_valid, if_s.tx_underrun});
         end
      end
   endtask

   task automatic test_impulse(input bit b);
      int want;
      rst = 1; enable = 0; tx_valid = 0; tick();
      rst = 0; enable = 1;
      for (int k = 0; k < 32; k++) begin
         tx_valid = (k == 0); tx_in = b;
         #1;
         chk++;
         if (if_r.tx_ready !== ((k % UPS) == 0)) begin
            err++; $display("FAIL impulse_ready cyc %0d got %b want %b", k, if_r.tx_ready, (k % UPS) == 0);
         end
         tick();
         want = (k < NC) ? (b ? k + 1 : -(k + 1)) : 0;
         chk++;
         if (if_r.tx_out !== DNB'(want) || if_r.tx_out_valid !== 1'b1) begin
            err++; $display("FAIL impulse_out bit %0d cyc %0d got %0d v%b want %0d v1", b, k,
                            $signed(if_r.tx_out), if_r.tx_out_valid, want);
         end
         chk++;
         if (if_r.tx_underrun !== (k > 0 && (k % UPS) == 0)) begin
            err++; $display("FAIL impulse_underrun cyc %0d got %b want %b", k, if_r.tx_underrun,
                            k > 0 && (k % UPS) == 0);
         end
         chk++;
         if (if_s.tx_out !== DNB'(exp_out[1])) begin
            err++; $display("FAIL impulse_full_out cyc %0d got %0d want %0d", k, $signed(if_s.tx_out), exp_out[1]);
         end
      end
   endtask

   task automatic test_saturation(input bit b);
      int want;
      rst = 1; enable = 0; tx_valid = 0; tick();
      rst = 0; enable = 1; tx_valid = 1; tx_in = b;
      for (int k = 0; k < 48; k++) begin
         tick();
         want = (k < UPS) ? (b ? 127 : -127) : (b ? 127 : -128);
         chk++;
         if (if_s.tx_out !== DNB'(want) || if_s.tx_out !== DNB'(exp_out[1])) begin
            err++; $display("FAIL sat_out bit %0d cyc %0d got %0d want %0d", b, k, $signed(if_s.tx_out), want);
         end
         chk++;
         if (if_r.tx_out !== DNB'(exp_out[0]) || if_r.tx_underrun !== 1'b0) begin
            err++; $display("FAIL sat_ramp cyc %0d got %0d ur%b want %0d ur0", k,
                            $signed(if_r.tx_out), if_r.tx_underrun, exp_out[0]);
         end
      end
   endtask

   task automatic test_enable_gaps();
      int n_en, want;
      bit e;
      rst = 1; enable = 0; tx_valid = 0; tick();
      rst = 0; tx_in = 1; n_en = 0; want = 0;
      for (int k = 0; k < 90; k++) begin
         e = ((k % 3) == 0);
         enable = e; tx_valid = (k == 0);
         #1;
         chk++;
         if (if_r.tx_ready !== (e && (n_en % UPS) == 0)) begin
            err++; $display("FAIL gap_ready cyc %0d got %b want %b", k, if_r.tx_ready, e && (n_en % UPS) == 0);
         end
         tick();
         if (e) begin
            want = (n_en < NC) ? n_en + 1 : 0;
         end
         chk++;
         if (if_r.tx_out !== DNB'(want) || if_r.tx_out_valid !== e) begin
            err++; $display("FAIL gap_out cyc %0d got %0d v%b want %0d v%b", k,
                            $signed(if_r.tx_out), if_r.tx_out_valid, want, e);
         end
         chk++;
         if (if_r.tx_underrun !== (e && n_en > 0 && (n_en % UPS) == 0)) begin
            err++; $display("FAIL gap_underrun cyc %0d got %b want %b", k, if_r.tx_underrun,
                            e && n_en > 0 && (n_en % UPS) == 0);
         end
         if (e) n_en++;
      end
      enable = 1;
   endtask

   task automatic test_midreset();
      rst = 1; enable = 0; tx_valid = 0; tick();
      rst = 0; enable = 1; tx_valid = 1; tx_in = 1;
      for (int k = 0; k < 30; k++) tick();
      chk++;
      if (if_s.tx_out !== DNB'(127)) begin
         err++; $display("FAIL midrst_pre got %0d want 127", $signed(if_s.tx_out));
      end
      rst = 1;
      #1;
      chk++;
      if (if_r.tx_ready !== 1'b0) begin
         err++; $display("FAIL midrst_ready got %b want 0", if_r.tx_ready);
      end
      tick();
      chk++;
      if (if_r.tx_out !== '0 || if_s.tx_out !== '0 || if_s.tx_out_valid !== 1'b0) begin
         err++; $display("FAIL midrst_clear got %0d/%0d v%b want 0/0 v0",
                         $signed(if_r.tx_out), $signed(if_s.tx_out), if_s.tx_out_valid);
      end
      rst = 0;
      for (int k = 0; k < 28; k++) begin
         tx_valid = (k == 0);
         tick();
         chk++;
         if (if_r.tx_out !== DNB'((k < NC) ? k + 1 : 0)) begin
            err++; $display("FAIL midrst_restart cyc %0d got %0d want %0d", k,
                            $signed(if_r.tx_out), (k < NC) ? k + 1 : 0);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         rst      = ($urandom_range(0, 149) == 0);
         enable   = ($urandom_range(0, 3) != 0);
         tx_valid = ($urandom_range(0, 4) != 0);
         tx_in    = 1'($urandom);
         #1;
         chk++;
         if (if_r.tx_ready !== exp_ready() || if_s.tx_ready !== exp_ready()) begin
            err++; $display("FAIL rand_ready cyc %0d got %b/%b want %b", k, if_r.tx_ready, if_s.tx_ready, exp_ready());
         end
         tick();
         chk++;
         if (if_r.tx_out !== DNB'(exp_out[0]) || if_s.tx_out !== DNB'(exp_out[1])) begin
            err++; $display("FAIL rand_out cyc %0d got %0d/%0d want %0d/%0d", k,
                            $signed(if_r.tx_out), $signed(if_s.tx_out), exp_out[0], exp_out[1]);
         end
         chk++;
         if (if_r.tx_out_valid !== exp_ov || if_s.tx_out_valid !== exp_ov ||
             if_r.tx_underrun !== exp_ur || if_s.tx_underrun !== exp_ur) begin
            err++; $display("FAIL rand_flags cyc %0d got v%b%b u%b%b want v%b u%b", k,
                            if_r.tx_out_valid, if_s.tx_out_valid, if_r.tx_underrun, if_s.tx_underrun,
                            exp_ov, exp_ur);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NC; i++) begin
         coef_m[0][i] = i + 1;
         coef_m[1][i] = 127;
         hist[i] = 0;
      end
      cnt = 0; exp_out[0] = 0; exp_out[1] = 0; exp_ov = 0; exp_ur = 0;
      test_reset();
      test_impulse(1'b1);
      test_impulse(1'b0);
      test_saturation(1'b1);
      test_saturation(1'b0);
      test_enable_gaps();
      test_midreset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
